miss_fill_sequencer: RTL and testbench
======================================

MISS_FILL_SEQUENCER -- requirements
Module: miss_fill_sequencer

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 2: miss queue entries, power of two, range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023: WAIT cycles before timeout flag, range 1..65535.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 main_clk  in  1  sole clock, all logic on rising edge.
REQ-005 main_rst  in  1  synchronous active-high reset.
REQ-006 miss_valid  in  1  cache presents a line miss.
REQ-007 miss_ready  out  1  queue can accept a miss.
REQ-008 miss_addr_read  in  22  line address to fill.
REQ-009 miss_tag_write  in  11  upper 11 bits of victim line address; low 11 bits equal miss_addr_read[10:0].
REQ-010 miss_dirty  in  1  victim must be written back.
REQ-011 miss_wdata  in  128  victim line data.
REQ-012 fill_valid  out  1  fill data available.
REQ-013 fill_ready  in  1  cache consumes fill.
REQ-014 fill_addr  out  22  address of returned line.
REQ-015 fill_data  out  128  returned line.
REQ-016 addr_req_read_dram_side_dram  out  11  miss_addr_read[21:11] of active entry.
REQ-017 addr_req_write_dram_side_dram  out  11  miss_tag_write of active entry.
REQ-018 addr_req_common_side_dram  out  11  miss_addr_read[10:0] of active entry.
REQ-019 lane_from_cache_to_dram_side_dram  out  128  victim data of active entry.
REQ-020 dram_controller_entry_dirty_side_dram  out  1  dirty flag of active entry.
REQ-021 dram_controller_req_read_pulse_side_dram  out  1  single-cycle request pulse.
REQ-022 dram_controller_ack_read_pulse_side_dram  in  1  single-cycle completion pulse.
REQ-023 lane_from_dram_to_cache_side_dram  in  128  read line, valid in the ack cycle.
REQ-024 err_flags  out  2  sticky: [0] timeout, [1] spurious ack.

Function
REQ-025 Miss queue SHALL be an in-order FIFO of QUEUE_DEPTH entries {addr_read, tag_write, dirty, wdata}; miss_ready = !full, registered-state only, no same-cycle bypass from pop to push.
REQ-026 Push SHALL occur on any cycle with miss_valid && miss_ready; miss_valid while full SHALL be ignored, queue unchanged.
REQ-027 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-028 IDLE: if queue non-empty, pop head into active-entry register and go to ISSUE; else stay.
REQ-029 ISSUE: drive req pulse high for exactly this one cycle; go to WAIT; clear timeout counter.
REQ-030 WAIT: on ack, capture lane_from_dram_to_cache_side_dram into fill_data, active addr into fill_addr, go to RESP; else increment 16-bit timeout counter, saturating.
REQ-031 When the WAIT counter equals TIMEOUT_CYCLES, err_flags[0] SHALL set; FSM stays in WAIT, no re-issue.
REQ-032 RESP: fill_valid=1; on fill_ready go to IDLE; fill_data/fill_addr SHALL hold stable while fill_valid and !fill_ready.
REQ-033 All *_side_dram address, data and dirty outputs SHALL be driven from the active-entry register and remain stable from the ISSUE cycle through the ack cycle inclusive.
REQ-034 Ack in IDLE, ISSUE or RESP SHALL be ignored for data and SHALL set err_flags[1].
REQ-035 Latency: miss accepted in cycle t into an empty queue with FSM in IDLE -> req pulse in cycle t+2; ack in cycle a -> fill_valid from cycle a+1.
REQ-036 Push and pop in the same cycle SHALL both take effect; count unchanged; pointers wrap modulo QUEUE_DEPTH.
REQ-037 At most one outstanding DRAM request at any time.

Reset
REQ-038 On main_rst: FSM=IDLE, queue empty, pointers 0, miss_ready=1 on the following cycle, fill_valid=0, req pulse=0, err_flags=0, fill_data=0, fill_addr=0, all *_side_dram outputs=0, timeout counter=0.
REQ-039 Reset mid-transaction SHALL abandon the active entry and all queued entries; an ack arriving after reset SHALL set err_flags[1].

Verification
REQ-040 Single clean miss: addr_read=22'h12345, dirty=0, ack 20 cycles after pulse with lane 128'hA5.. -> one pulse at t+2, fill_addr=22'h12345, fill_data=lane, fill_valid until fill_ready.
REQ-041 Dirty miss: tag_write=11'h7FF, wdata=128'hDEAD.. -> read/write/common outputs = 11'h024/11'h7FF/11'h345 and wdata stable pulse through ack.
REQ-042 Fill three misses back-to-back with QUEUE_DEPTH=2, no acks -> miss_ready low after two queued plus one active; fills returned in order A,B,C.
REQ-043 fill_ready held low 10 cycles in RESP -> fill_data stable; no new pulse until RESP exits.
REQ-044 TIMEOUT_CYCLES=15, no ack -> err_flags[0]=1 at 15th WAIT cycle; later ack still completes fill.
REQ-045 Ack injected in IDLE, then main_rst during WAIT -> err_flags[1]=1, then all outputs at reset values next cycle.

Source files
------------

// File: rtl/miss_fill_sequencer.sv
// rtl/miss_fill_sequencer.sv - in-order miss queue feeding a single-outstanding DRAM fill sequencer
// One request is in flight at a time; side_dram outputs reflect the active entry until the next pop.

module miss_fill_sequencer #(
    parameter int QUEUE_DEPTH    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         main_clk,
    input  logic         main_rst,
    input  logic         miss_valid,
    output logic         miss_ready,
    input  logic [21:0]  miss_addr_read,
    input  logic [10:0]  miss_tag_write,
    input  logic         miss_dirty,
    input  logic [127:0] miss_wdata,
    output logic         fill_valid,
    input  logic         fill_ready,
    output logic [21:0]  fill_addr,
    output logic [127:0] fill_data,
    output logic [10:0]  addr_req_read_dram_side_dram,
    output logic [10:0]  addr_req_write_dram_side_dram,
    output logic [10:0]  addr_req_common_side_dram,
    output logic [127:0] lane_from_cache_to_dram_side_dram,
    output logic         dram_controller_entry_dirty_side_dram,
    output logic         dram_controller_req_read_pulse_side_dram,
    input  logic         dram_controller_ack_read_pulse_side_dram,
    input  logic [127:0] lane_from_dram_to_cache_side_dram,
    output logic [1:0]   err_flags
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [21:0]  addr;
        logic [10:0]  tag;
        logic         dirty;
        logic [127:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    entry_t           q_mem [QUEUE_DEPTH];
    entry_t           entry_in;
    entry_t           active;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;
    logic             push;
    logic             pop;
    state_t           state;
    logic [15:0]      wait_cnt;

    assign q_full     = (q_count == CNT_W'(QUEUE_DEPTH));
    assign q_empty    = (q_count == '0);
    assign miss_ready = !q_full;
    assign push       = miss_valid && miss_ready;
    assign pop        = (state == IDLE) && !q_empty;

    assign entry_in = '{addr: miss_addr_read, tag: miss_tag_write,
                        dirty: miss_dirty, wdata: miss_wdata};

    assign addr_req_read_dram_side_dram          = active.addr[21:11];
    assign addr_req_write_dram_side_dram         = active.tag;
    assign addr_req_common_side_dram             = active.addr[10:0];
    assign lane_from_cache_to_dram_side_dram     = active.wdata;
    assign dram_controller_entry_dirty_side_dram = active.dirty;

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge main_clk) begin
        if (push) begin
            q_mem[wr_ptr] <= entry_in;
        end
    end

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            wr_ptr                                   <= '0;
            rd_ptr                                   <= '0;
            q_count                                  <= '0;
            state                                    <= IDLE;
            active                                   <= '0;
            wait_cnt                                 <= '0;
            fill_valid                               <= 1'b0;
            fill_addr                                <= '0;
            fill_data                                <= '0;
            dram_controller_req_read_pulse_side_dram <= 1'b0;
            err_flags                                <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase

            if (dram_controller_ack_read_pulse_side_dram && (state != WAIT)) begin
                err_flags[1] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        active                                   <= q_mem[rd_ptr];
                        dram_controller_req_read_pulse_side_dram <= 1'b1;
                        state                                    <= ISSUE;
                    end
                end
                ISSUE: begin
                    dram_controller_req_read_pulse_side_dram <= 1'b0;
                    wait_cnt                                 <= '0;
                    state                                    <= WAIT;
                end
                WAIT: begin
                    if (dram_controller_ack_read_pulse_side_dram) begin
                        fill_data  <= lane_from_dram_to_cache_side_dram;
                        fill_addr  <= active.addr;
                        fill_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        if (wait_cnt != 16'hFFFF) begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                        // Flag on the edge where the count of idle WAIT cycles reaches the limit.
                        if ((wait_cnt + 16'd1) == 16'(TIMEOUT_CYCLES)) begin
                            err_flags[0] <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (fill_ready) begin
                        fill_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miss_fill_sequencer.sv
// tb/tb_miss_fill_sequencer.sv - vector table, corner sequences and randomized scoreboard run
// Inputs are driven and outputs sampled on the falling edge.

module tb_miss_fill_sequencer;

    logic         main_clk = 1'b0;
    logic         main_rst = 1'b1;
    logic         miss_valid = 1'b0;
    logic         miss_ready;
    logic [21:0]  miss_addr_read = '0;
    logic [10:0]  miss_tag_write = '0;
    logic         miss_dirty = 1'b0;
    logic [127:0] miss_wdata = '0;
    logic         fill_valid;
    logic         fill_ready = 1'b0;
    logic [21:0]  fill_addr;
    logic [127:0] fill_data;
    logic [10:0]  rd_o, wr_o, cm_o;
    logic [127:0] wd_o;
    logic         dty_o, req_o;
    logic         ack_i = 1'b0;
    logic [127:0] lane_i = '0;
    logic [1:0]   err_flags;
    logic [161:0] side_now;

    assign side_now = {rd_o, wr_o, cm_o, wd_o, dty_o};

    miss_fill_sequencer #(.QUEUE_DEPTH(2), .TIMEOUT_CYCLES(15)) dut (
        .main_clk                                 (main_clk),
        .main_rst                                 (main_rst),
        .miss_valid                               (miss_valid),
        .miss_ready                               (miss_ready),
        .miss_addr_read                           (miss_addr_read),
        .miss_tag_write                           (miss_tag_write),
        .miss_dirty                               (miss_dirty),
        .miss_wdata                               (miss_wdata),
        .fill_valid                               (fill_valid),
        .fill_ready                               (fill_ready),
        .fill_addr                                (fill_addr),
        .fill_data                                (fill_data),
        .addr_req_read_dram_side_dram             (rd_o),
        .addr_req_write_dram_side_dram            (wr_o),
        .addr_req_common_side_dram                (cm_o),
        .lane_from_cache_to_dram_side_dram        (wd_o),
        .dram_controller_entry_dirty_side_dram    (dty_o),
        .dram_controller_req_read_pulse_side_dram (req_o),
        .dram_controller_ack_read_pulse_side_dram (ack_i),
        .lane_from_dram_to_cache_side_dram        (lane_i),
        .err_flags                                (err_flags)
    );

    always #5 main_clk = ~main_clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [21:0]  addr;
        logic [10:0]  tag;
        logic         dirty;
        logic [127:0] wdata;
        logic [127:0] lane;
        int           ack_dly;
        int           rdy_dly;
        logic [10:0]  exp_rd;
        logic [10:0]  exp_wr;
        logic [10:0]  exp_cm;
        logic [1:0]   exp_err;
    } vec_t;

    typedef struct {
        logic [21:0]  addr;
        logic [10:0]  tag;
        logic         dirty;
        logic [127:0] wdata;
    } miss_t;

    typedef struct {
        logic [21:0]  addr;
        logic [127:0] data;
    } fill_t;

    vec_t  vecs [4];
    miss_t pend [$];
    fill_t fexp [$];
    miss_t cur;
    miss_t nm;
    fill_t fe;
    int    ack_cnt;
    bit    outst;
    bit    just;
    int    accepted;
    int    filled;
    int    stab_bad;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge main_clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset;
        main_rst   = 1'b1;
        miss_valid = 1'b0;
        fill_ready = 1'b0;
        ack_i      = 1'b0;
        tick;
        tick;
        main_rst = 1'b0;
    endtask

    task automatic set_miss(input logic [21:0] a, input logic [10:0] t, input logic d,
                            input logic [127:0] w);
        miss_addr_read = a;
        miss_tag_write = t;
        miss_dirty     = d;
        miss_wdata     = w;
        miss_valid     = 1'b1;
    endtask

    task automatic push_miss(input logic [21:0] a, input logic [10:0] t, input logic d,
                             input logic [127:0] w);
        set_miss(a, t, d, w);
        tick;
        miss_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        while (req_o !== 1'b1 && n < limit) begin
            tick;
            n++;
        end
    endtask

    task automatic chk_reset_outs(input string p);
        chk({p, "_miss_ready"}, miss_ready, 1);
        chk({p, "_fill_valid"}, fill_valid, 0);
        chk({p, "_req"}, req_o, 0);
        chk({p, "_err"}, err_flags, 0);
        chk({p, "_fill_addr"}, fill_addr, 0);
        chk({p, "_fill_data"}, fill_data, 0);
        chk({p, "_side_addr"}, {rd_o, wr_o, cm_o, dty_o}, 0);
        chk({p, "_side_wdata"}, wd_o, 0);
    endtask

    // Waits for the next request, checks its address, acks and drains the fill.
    task automatic serve(input string p, input logic [21:0] a, input logic [127:0] lane);
        int n;
        wait_pulse(30, n);
        chk({p, "_pulse"}, req_o, 1);
        chk({p, "_req_addr"}, {rd_o, cm_o}, a);
        tick;
        ack_i  = 1'b1;
        lane_i = lane;
        tick;
        ack_i  = 1'b0;
        lane_i = rnd128();
        chk({p, "_fill_valid"}, fill_valid, 1);
        chk({p, "_fill_addr"}, fill_addr, a);
        chk({p, "_fill_data"}, fill_data, lane);
        fill_ready = 1'b1;
        tick;
        fill_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int           n;
        bit           bad;
        logic [161:0] saved;
        string        p;
        p = $sformatf("v%0d", idx);
        do_reset;
        chk({p, "_ready"}, miss_ready, 1);
        push_miss(v.addr, v.tag, v.dirty, v.wdata);
        wait_pulse(8, n);
        chk({p, "_pulse_latency"}, n, 1);
        chk({p, "_rd"}, rd_o, v.exp_rd);
        chk({p, "_wr"}, wr_o, v.exp_wr);
        chk({p, "_cm"}, cm_o, v.exp_cm);
        chk({p, "_dirty"}, dty_o, v.dirty);
        chk({p, "_wdata"}, wd_o, v.wdata);
        saved = side_now;
        bad   = 1'b0;
        tick;
        chk({p, "_pulse_width"}, req_o, 0);
        for (int c = 1; c < v.ack_dly; c++) begin
            if (req_o || side_now !== saved) bad = 1'b1;
            tick;
        end
        if (side_now !== saved) bad = 1'b1;
        ack_i  = 1'b1;
        lane_i = v.lane;
        tick;
        ack_i  = 1'b0;
        lane_i = rnd128();
        chk({p, "_side_stable"}, bad, 0);
        chk({p, "_fill_valid"}, fill_valid, 1);
        chk({p, "_fill_addr"}, fill_addr, v.addr);
        chk({p, "_fill_data"}, fill_data, v.lane);
        chk({p, "_err"}, err_flags, v.exp_err);
        bad = 1'b0;
        for (int c = 0; c < v.rdy_dly; c++) begin
            tick;
            if (!fill_valid || fill_data !== v.lane || fill_addr !== v.addr || req_o) bad = 1'b1;
        end
        chk({p, "_fill_hold"}, bad, 0);
        fill_ready = 1'b1;
        tick;
        fill_ready = 1'b0;
        chk({p, "_fill_done"}, fill_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;

        vecs[0] = '{addr: 22'h12345, tag: 11'h000, dirty: 1'b0, wdata: 128'h0,
                    lane: {16{8'hA5}}, ack_dly: 20, rdy_dly: 0,
                    exp_rd: 11'h024, exp_wr: 11'h000, exp_cm: 11'h345, exp_err: 2'b01};
        vecs[1] = '{addr: 22'h12345, tag: 11'h7FF, dirty: 1'b1, wdata: {8{16'hDEAD}},
                    lane: 128'h0123456789ABCDEF_FEDCBA9876543210, ack_dly: 3, rdy_dly: 10,
                    exp_rd: 11'h024, exp_wr: 11'h7FF, exp_cm: 11'h345, exp_err: 2'b00};
        vecs[2] = '{addr: 22'h3FFFFF, tag: 11'h155, dirty: 1'b1, wdata: {4{32'hCAFEF00D}},
                    lane: {4{32'h5A5A0FF0}}, ack_dly: 1, rdy_dly: 2,
                    exp_rd: 11'h7FF, exp_wr: 11'h155, exp_cm: 11'h7FF, exp_err: 2'b00};
        vecs[3] = '{addr: 22'h000800, tag: 11'h2AA, dirty: 1'b0, wdata: {2{64'h1}},
                    lane: {128{1'b1}}, ack_dly: 14, rdy_dly: 1,
                    exp_rd: 11'h001, exp_wr: 11'h2AA, exp_cm: 11'h000, exp_err: 2'b00};

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Three back-to-back misses with depth 2: two queued plus one active fills it.
        do_reset;
        chk("q3_ready0", miss_ready, 1);
        set_miss(22'h0000A1, 11'h011, 1'b0, rnd128());
        tick;
        chk("q3_ready1", miss_ready, 1);
        set_miss(22'h0000B2, 11'h022, 1'b1, rnd128());
        tick;
        chk("q3_pulse_a", req_o, 1);
        chk("q3_pulse_a_addr", cm_o, 11'h0A1);
        chk("q3_ready2", miss_ready, 1);
        set_miss(22'h0000C3, 11'h033, 1'b0, rnd128());
        tick;
        chk("q3_full", miss_ready, 0);
        set_miss(22'h0000D4, 11'h044, 1'b1, rnd128());
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (miss_ready) bad = 1'b1;
        end
        miss_valid = 1'b0;
        chk("q3_full_hold", bad, 0);
        ack_i  = 1'b1;
        lane_i = {4{32'hAAAA0001}};
        tick;
        ack_i  = 1'b0;
        lane_i = rnd128();
        chk("q3_fill_a_addr", fill_addr, 22'h0000A1);
        chk("q3_fill_a_data", fill_data, {4{32'hAAAA0001}});
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (req_o || !fill_valid || fill_data !== {4{32'hAAAA0001}}) bad = 1'b1;
        end
        chk("q3_resp_hold_no_pulse", bad, 0);
        fill_ready = 1'b1;
        tick;
        fill_ready = 1'b0;
        serve("q3_b", 22'h0000B2, {4{32'hBBBB0002}});
        serve("q3_c", 22'h0000C3, {4{32'hCCCC0003}});
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (req_o) bad = 1'b1;
            tick;
        end
        chk("q3_d_ignored", bad, 0);

        // Timeout with limit 15, then a late ack still completes.
        do_reset;
        push_miss(22'h2ABCD, 11'h123, 1'b1, rnd128());
        wait_pulse(8, n);
        chk("to_pulse", req_o, 1);
        bad = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick;
            if (req_o) bad = 1'b1;
        end
        chk("to_before_limit", err_flags[0], 0);
        tick;
        tick;
        chk("to_after_limit", err_flags[0], 1);
        for (int c = 0; c < 4; c++) begin
            if (req_o) bad = 1'b1;
            tick;
        end
        chk("to_no_reissue", bad, 0);
        ack_i  = 1'b1;
        lane_i = {2{64'h0BADF00D_12345678}};
        tick;
        ack_i  = 1'b0;
        chk("to_fill_valid", fill_valid, 1);
        chk("to_fill_data", fill_data, {2{64'h0BADF00D_12345678}});
        chk("to_err", err_flags, 2'b01);
        fill_ready = 1'b1;
        tick;
        fill_ready = 1'b0;

        // Spurious ack in IDLE, then reset in the middle of WAIT.
        do_reset;
        chk_reset_outs("rst0");
        push_miss(22'h1F00F, 11'h0F0, 1'b1, {4{32'h77777777}});
        serve("sp_fill", 22'h1F00F, {4{32'h13579BDF}});
        ack_i = 1'b1;
        tick;
        ack_i = 1'b0;
        chk("sp_idle_ack", err_flags, 2'b10);
        push_miss(22'h0F0F0, 11'h555, 1'b1, {4{32'h99999999}});
        wait_pulse(8, n);
        chk("sp_pulse", req_o, 1);
        tick;
        main_rst = 1'b1;
        tick;
        main_rst = 1'b0;
        chk_reset_outs("rst_mid");
        ack_i = 1'b1;
        tick;
        ack_i = 1'b0;
        chk("sp_post_reset_ack", err_flags, 2'b10);
        chk("sp_post_reset_fill", fill_valid, 0);

        // Randomized traffic against an in-order scoreboard.
        do_reset;
        outst    = 1'b0;
        accepted = 0;
        filled   = 0;
        stab_bad = 0;
        ack_cnt  = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            just = 1'b0;
            if (req_o) begin
                chk("rnd_one_outstanding", outst, 0);
                chk("rnd_no_fill_pending", fill_valid, 0);
                chk("rnd_pulse_has_entry", pend.size() > 0, 1);
                if (pend.size() > 0) begin
                    cur = pend.pop_front();
                    chk("rnd_req_addr", {rd_o, wr_o, cm_o}, {cur.addr[21:11], cur.tag, cur.addr[10:0]});
                    chk("rnd_req_data", {dty_o, wd_o}, {cur.dirty, cur.wdata});
                end
                outst   = 1'b1;
                just    = 1'b1;
                ack_cnt = $urandom_range(1, 12);
            end else if (outst) begin
                if ({rd_o, wr_o, cm_o, dty_o, wd_o} !==
                    {cur.addr[21:11], cur.tag, cur.addr[10:0], cur.dirty, cur.wdata})
                    stab_bad++;
            end

            ack_i  = 1'b0;
            lane_i = rnd128();
            if (outst && !just) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    ack_i   = 1'b1;
                    fe.addr = cur.addr;
                    fe.data = lane_i;
                    fexp.push_back(fe);
                    outst = 1'b0;
                end
            end

            fill_ready = ($urandom_range(0, 3) != 0);
            if (fill_valid && fill_ready) begin
                chk("rnd_fill_expected", fexp.size() > 0, 1);
                if (fexp.size() > 0) begin
                    fe = fexp.pop_front();
                    chk("rnd_fill_addr", fill_addr, fe.addr);
                    chk("rnd_fill_data", fill_data, fe.data);
                end
                filled++;
            end

            miss_valid = (cyc < 3500) && ($urandom_range(0, 2) == 0);
            nm.addr  = 22'($urandom);
            nm.tag   = 11'($urandom);
            nm.dirty = 1'($urandom);
            nm.wdata = rnd128();
            miss_addr_read = nm.addr;
            miss_tag_write = nm.tag;
            miss_dirty     = nm.dirty;
            miss_wdata     = nm.wdata;
            if (miss_valid && miss_ready) begin
                pend.push_back(nm);
                accepted++;
            end
            tick;
        end
        miss_valid = 1'b0;
        fill_ready = 1'b0;
        chk("rnd_side_stable", stab_bad, 0);
        chk("rnd_drained_queue", pend.size(), 0);
        chk("rnd_drained_fills", fexp.size(), 0);
        chk("rnd_fill_count", filled, accepted);
        chk("rnd_idle_at_end", outst, 0);
        chk("rnd_no_errors", err_flags, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
